cory_spram_arb: RTL

- Two-requester arbiter and sequencer in front of one single-port RAM (csn/wen/oen, active-low controls, 1-cycle registered read).
- Accepts valid/ready requests from ports 0 and 1 and grants one access per cycle, round-robin.
- Drives the RAM control, address and write-data pins.
- Returns read data on a shared response channel tagged with the port id, with backpressure.

---
 rtl/cory_spram_arb_pkg.sv | 9 +
 rtl/cory_rr_arb2.sv | 16 +
 rtl/cory_spram_arb.sv | 105 ++++++++++
 3 files changed

// File: rtl/cory_spram_arb_pkg.sv
// cory_spram_arb_pkg: shared constants and op encoding for the SPRAM arbiter
package cory_spram_arb_pkg;
    localparam int PORTS = 2;
    localparam int STAT_W = 32;
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;
endpackage

// File: rtl/cory_rr_arb2.sv
// cory_rr_arb2: two-input round-robin arbiter; pointer holds the last granted port
module cory_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic ptr;
    assign gnt[0] = req[0] & (~req[1] | ptr);
    assign gnt[1] = req[1] & (~req[0] | ~ptr);
    // remember the winner so the other port goes first on the next contention
    always_ff @(posedge clk)
        if (reset) ptr <= 1'b1;
        else if (en) ptr <= gnt[1];
endmodule

// File: rtl/cory_spram_arb.sv
// cory_spram_arb: two-port round-robin sequencer for a single-port RAM; grant stats under `CORY_SPRAM_ARB_STAT_EN
module cory_spram_arb
    import cory_spram_arb_pkg::*;
#(
    parameter int A = 8,
    parameter int D = 8,
    parameter int SIZE = 2**A
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PORTS-1:0]    i_req_valid,
    output logic [PORTS-1:0]    o_req_ready,
    input  logic [PORTS-1:0]    i_req_write,
    input  logic [PORTS*A-1:0]  i_req_addr,
    input  logic [PORTS*D-1:0]  i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic                o_rsp_id,
    output logic [D-1:0]        o_rsp_data,
    output logic                o_rsp_err,
    output logic                o_err,
    output logic                o_ram_csn,
    output logic                o_ram_wen,
    output logic                o_ram_oen,
    output logic [A-1:0]        o_ram_addr,
    output logic [D-1:0]        o_ram_wdata,
    input  logic [D-1:0]        i_ram_rdata,
    output logic [STAT_W-1:0]   o_stat_gnt0,
    output logic [STAT_W-1:0]   o_stat_gnt1,
    output logic [STAT_W-1:0]   o_stat_conf
);
    logic [PORTS-1:0] elig, gnt;
    logic blocked, hit, sel, g, oob, rd, rsp_valid, rsp_id, rsp_err;
    logic [A-1:0] addr_g;
    logic [D-1:0] wdata_g;

    // a new read would clobber the RAM output register while a response is stalled
    assign blocked = rsp_valid & ~i_rsp_ready;
    assign elig = reset ? '0 : i_req_valid & (i_req_write | {PORTS{~blocked}});

    cory_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .en    (hit),
        .gnt   (gnt)
    );

    assign hit = |gnt;
    assign g = gnt[1];
    assign addr_g = g ? i_req_addr[2*A-1:A] : i_req_addr[A-1:0];
    assign wdata_g = g ? i_req_wdata[2*D-1:D] : i_req_wdata[D-1:0];
    assign oob = 32'(addr_g) >= SIZE;
    assign sel = hit & ~oob;
    assign rd = hit & (i_req_write[g] == OP_RD);

    assign o_req_ready = gnt;
    assign o_err = hit & oob;
    assign o_ram_csn = ~sel;
    assign o_ram_wen = ~(sel & (i_req_write[g] == OP_WR));
    assign o_ram_addr = sel ? addr_g : '0;
    assign o_ram_wdata = sel ? wdata_g : '0;

    assign o_rsp_valid = rsp_valid;
    assign o_rsp_id = rsp_id;
    assign o_rsp_err = rsp_valid & rsp_err;
    assign o_rsp_data = (rsp_valid & ~rsp_err) ? i_ram_rdata : '0;
    assign o_ram_oen = ~rsp_valid;

    // response slot: loaded by an accepted read, cleared when the consumer takes it
    always_ff @(posedge clk)
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id <= 1'b0;
            rsp_err <= 1'b0;
        end else if (rd) begin
            rsp_valid <= 1'b1;
            rsp_id <= g;
            rsp_err <= oob;
        end else if (i_rsp_ready) begin
            rsp_valid <= 1'b0;
        end

`ifdef CORY_SPRAM_ARB_STAT_EN
    logic [STAT_W-1:0] gnt0, gnt1, conf;
    // saturating grant and contention counters
    always_ff @(posedge clk)
        if (reset) begin
            gnt0 <= '0;
            gnt1 <= '0;
            conf <= '0;
        end else begin
            if (gnt[0] && !(&gnt0)) gnt0 <= gnt0 + 1'b1;
            if (gnt[1] && !(&gnt1)) gnt1 <= gnt1 + 1'b1;
            if ((&i_req_valid) && hit && !(&conf)) conf <= conf + 1'b1;
        end
    assign o_stat_gnt0 = gnt0;
    assign o_stat_gnt1 = gnt1;
    assign o_stat_conf = conf;
`else
    assign o_stat_gnt0 = '0;
    assign o_stat_gnt1 = '0;
    assign o_stat_conf = '0;
`endif
endmodule
